// File: rtl/alu_pkg.sv
// Shared constants, FSM state encoding and instruction type for the ALU issue stage.
package alu_pkg;
   localparam int INSTR_W = 12;
   localparam int RES_W   = 4;

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      WAIT
   } issue_state_t;

   typedef logic [INSTR_W-1:0] instr_t;
endpackage

// File: rtl/alu_instr_fifo.sv
// Instruction buffer: DEPTH-entry circular FIFO, push accepted only while count < DEPTH.
// Zero-latency head read; a word pushed into an empty FIFO is visible at the head one cycle later.
module alu_instr_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 12
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic [W-1:0]             i_push_dat,
   input  logic                     i_push_vld,
   output logic                     o_push_rdy,
   input  logic                     i_pop,
   output logic [W-1:0]             o_head_dat,
   output logic [$clog2(DEPTH):0]   o_count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          w_push;
   logic          w_pop;

   // Ready looks only at registered occupancy, so a full FIFO refuses a push even when popping.
   assign o_push_rdy = (r_count < CW'(DEPTH));
   assign w_push     = i_push_vld && o_push_rdy;
   assign w_pop      = i_pop && (r_count != '0);
   assign o_head_dat = r_mem[r_rd_ptr];
   assign o_count    = r_count;

   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_push_dat;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end
endmodule

// File: rtl/alu_issue_stage.sv
// Buffers instruction words, issues one at a time to the ALU and returns its sum over valid/ready.
// Define ALU_ISSUE_STATS_EN to add the 16-bit done_cnt handshake counter output.
module alu_issue_stage #(
   parameter int DEPTH   = 4,
   parameter int INSTR_W = 12,
   parameter int RES_W   = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [INSTR_W-1:0]       instr_in,
   input  logic                     instr_valid,
   output logic                     instr_ready,
   output logic [INSTR_W-1:0]       alu_in,
   input  logic [RES_W-1:0]         alu_sum,
   output logic [RES_W-1:0]         res_out,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   fifo_count
`ifdef ALU_ISSUE_STATS_EN
   ,
   output logic [15:0]              done_cnt
`endif
);
   import alu_pkg::*;

   issue_state_t         r_state;
   issue_state_t         w_state_nxt;
   logic [INSTR_W-1:0]   r_alu_in;
   logic [RES_W-1:0]     r_res_out;
   logic                 r_res_valid;
   logic                 w_pop;
   logic                 w_cap;
   logic                 w_clr;
   logic [INSTR_W-1:0]   w_head;
   logic [$clog2(DEPTH):0] w_count;
   logic                 w_not_empty;

   alu_instr_fifo #(
      .DEPTH (DEPTH),
      .W     (INSTR_W)
   ) u_fifo (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_push_dat (instr_in),
      .i_push_vld (instr_valid),
      .o_push_rdy (instr_ready),
      .i_pop      (w_pop),
      .o_head_dat (w_head),
      .o_count    (w_count)
   );

   assign w_not_empty = (w_count != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_cap       = 1'b0;
      w_clr       = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_not_empty) begin
               w_pop       = 1'b1;
               w_state_nxt = EXEC;
            end
         end
         EXEC: begin
            w_cap       = 1'b1;
            w_state_nxt = WAIT;
         end
         WAIT: begin
            // Accepting the result and issuing the next word share one edge.
            if (res_ready) begin
               w_clr = 1'b1;
               if (w_not_empty) begin
                  w_pop       = 1'b1;
                  w_state_nxt = EXEC;
               end else begin
                  w_state_nxt = IDLE;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_alu_in    <= '0;
         r_res_out   <= '0;
         r_res_valid <= 1'b0;
      end else begin
         if (w_pop) begin
            r_alu_in <= w_head;
         end
         if (w_cap) begin
            r_res_out   <= alu_sum;
            r_res_valid <= 1'b1;
         end else if (w_clr) begin
            r_res_valid <= 1'b0;
         end
      end
   end

   assign alu_in     = r_alu_in;
   assign res_out    = r_res_out;
   assign res_valid  = r_res_valid;
   assign fifo_count = w_count;
   assign busy       = (r_state != IDLE) || w_not_empty;

`ifdef ALU_ISSUE_STATS_EN
   logic [15:0] r_done_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_done_cnt <= '0;
      end else if (r_res_valid && res_ready) begin
         r_done_cnt <= r_done_cnt + 16'd1;
      end
   end

   assign done_cnt = r_done_cnt;
`endif
endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a behavioural ALU stub (sum of the two low nibbles).
module tb_alu_issue_stage;
   localparam int DEPTH   = 4;
   localparam int INSTR_W = 12;
   localparam int RES_W   = 4;

   logic               clk;
   logic               rst_n;
   logic [INSTR_W-1:0] instr_in;
   logic               instr_valid;
   logic               instr_ready;
   logic [INSTR_W-1:0] alu_in;
   logic [RES_W-1:0]   alu_sum;
   logic [RES_W-1:0]   res_out;
   logic               res_valid;
   logic               res_ready;
   logic               busy;
   logic [2:0]         fifo_count;
`ifdef ALU_ISSUE_STATS_EN
   logic [15:0]        done_cnt;
`endif

   int tests_run;
   int tests_failed;
   int cyc;
   logic [RES_W-1:0] got_q[$];
   int               cyc_q[$];

   alu_issue_stage #(
      .DEPTH   (DEPTH),
      .INSTR_W (INSTR_W),
      .RES_W   (RES_W)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .instr_in    (instr_in),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .alu_in      (alu_in),
      .alu_sum     (alu_sum),
      .res_out     (res_out),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .busy        (busy),
      .fifo_count  (fifo_count)
`ifdef ALU_ISSUE_STATS_EN
      ,
      .done_cnt    (done_cnt)
`endif
   );

   assign alu_sum = alu_in[7:4] + alu_in[3:0];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Handshakes are recorded mid-cycle, ahead of the edge that completes them.
   always @(negedge clk) begin
      if (rst_n && res_valid && res_ready) begin
         got_q.push_back(res_out);
         cyc_q.push_back(cyc);
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_results(input int n, input int budget);
      for (int k = 0; k < budget && got_q.size() < n; k++) begin
         @(posedge clk);
      end
      #1;
   endtask

   logic [INSTR_W-1:0] stream_w [4];
   logic [RES_W-1:0]   stream_r [4];
   logic [INSTR_W-1:0] full_w   [6];
   logic [RES_W-1:0]   full_r   [5];

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      cyc          = 0;
      stream_w = '{12'h33A, 12'h32A, 12'h323, 12'h324};
      stream_r = '{4'hD, 4'hC, 4'h5, 4'h6};
      full_w   = '{12'h011, 12'h022, 12'h033, 12'h044, 12'h055, 12'h066};
      full_r   = '{4'h2, 4'h4, 4'h6, 4'h8, 4'hA};

      rst_n       = 1'b0;
      instr_in    = '0;
      instr_valid = 1'b0;
      res_ready   = 1'b0;
      repeat (3) tick();

      chk("rst_alu_in", alu_in, 0);
      chk("rst_res_out", res_out, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_instr_ready", instr_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_fifo_count", fifo_count, 0);
`ifdef ALU_ISSUE_STATS_EN
      chk("rst_done_cnt", done_cnt, 0);
`endif
      rst_n = 1'b1;
      tick();

      // Single instruction: alu_in at edge 1, result at edge 2.
      res_ready   = 1'b1;
      instr_in    = 12'h33A;
      instr_valid = 1'b1;
      tick();
      instr_valid = 1'b0;
      chk("single_count_e0", fifo_count, 1);
      chk("single_valid_e0", res_valid, 0);
      tick();
      chk("single_alu_in_e1", alu_in, 12'h33A);
      chk("single_valid_e1", res_valid, 0);
      tick();
      chk("single_res_out_e2", res_out, 4'hD);
      chk("single_valid_e2", res_valid, 1);
      tick();
      chk("single_valid_after_hs", res_valid, 0);
      chk("single_busy_after_hs", busy, 0);

      // Back-to-back stream with downstream always ready.
      got_q.delete();
      cyc_q.delete();
      for (int i = 0; i < 4; i++) begin
         instr_in    = stream_w[i];
         instr_valid = 1'b1;
         tick();
      end
      instr_valid = 1'b0;
      wait_results(4, 40);
      chk("stream_count", got_q.size(), 4);
      for (int i = 0; i < 4 && i < got_q.size(); i++) begin
         chk($sformatf("stream_res%0d", i), got_q[i], stream_r[i]);
      end
      for (int i = 1; i < 4 && i < cyc_q.size(); i++) begin
         chk($sformatf("stream_gap%0d", i), cyc_q[i] - cyc_q[i-1], 2);
      end
      chk("stream_busy_end", busy, 0);
`ifdef ALU_ISSUE_STATS_EN
      chk("stream_done_cnt", done_cnt, 5);
`endif

      // Fill under back-pressure: one issued, four buffered, sixth refused.
      got_q.delete();
      cyc_q.delete();
      res_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         instr_in    = full_w[i];
         instr_valid = 1'b1;
         tick();
      end
      instr_in = full_w[5];
      chk("full_instr_ready", instr_ready, 0);
      chk("full_fifo_count", fifo_count, 4);
      tick();
      instr_valid = 1'b0;
      repeat (3) tick();
      chk("full_fifo_count_hold", fifo_count, 4);
      chk("full_alu_in_stable", alu_in, 12'h011);
      chk("full_res_out_stable", res_out, 4'h2);
      chk("full_res_valid_hold", res_valid, 1);
      chk("full_no_handshake", got_q.size(), 0);
`ifdef ALU_ISSUE_STATS_EN
      chk("stall_done_cnt", done_cnt, 5);
`endif

      // Release back-pressure and drain in push order.
      res_ready = 1'b1;
      wait_results(5, 60);
      repeat (4) tick();
      chk("drain_count", got_q.size(), 5);
      for (int i = 0; i < 5 && i < got_q.size(); i++) begin
         chk($sformatf("drain_res%0d", i), got_q[i], full_r[i]);
      end
      chk("drain_fifo_empty", fifo_count, 0);
      chk("drain_busy", busy, 0);
`ifdef ALU_ISSUE_STATS_EN
      chk("drain_done_cnt", done_cnt, 10);
`endif

      // Reset while waiting with three words queued.
      res_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         instr_in    = stream_w[i];
         instr_valid = 1'b1;
         tick();
      end
      instr_valid = 1'b0;
      chk("midrst_pre_valid", res_valid, 1);
      chk("midrst_pre_count", fifo_count, 3);
      rst_n = 1'b0;
      #1;
      chk("midrst_res_valid", res_valid, 0);
      chk("midrst_fifo_count", fifo_count, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_alu_in", alu_in, 0);
`ifdef ALU_ISSUE_STATS_EN
      chk("midrst_done_cnt", done_cnt, 0);
`endif
      repeat (2) tick();
      rst_n = 1'b1;
      got_q.delete();
      cyc_q.delete();
      res_ready = 1'b1;
      repeat (10) tick();
      chk("midrst_no_stale", got_q.size(), 0);
      chk("midrst_busy_after", busy, 0);
      chk("midrst_ready_after", instr_ready, 1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Upstream feeder for the 12-bit ALU.
- Buffers incoming instruction words in a small FIFO and issues them one at a time onto the ALU `in` bus.
- Registers the ALU's 4-bit `sum` and presents it downstream with a valid/ready handshake.
- Replaces the hand-timed `#20` stimulus with a clocked, back-pressured sequencer.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- INSTR_W, 12, instruction word width driven to ALU `in`.
- RES_W, 4, ALU result width.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- instr_in  input  INSTR_W  instruction word from the upstream source.
- instr_valid  input  1  instr_in is valid.
- instr_ready  output  1  FIFO can accept a word this cycle.
- alu_in  output  INSTR_W  registered word driving ALU `in`.
- alu_sum  input  RES_W  ALU `sum`; combinational function of alu_in.
- res_out  output  RES_W  captured result.
- res_valid  output  1  res_out is valid.
- res_ready  input  1  downstream accepts res_out.
- busy  output  1  high when state is not IDLE or FIFO count is above 0.
- fifo_count  output  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Async reset: FIFO is emptied (pointers and count = 0), state = IDLE, and every output is cleared: alu_in = 0, res_out = 0, res_valid = 0, instr_ready = 1, busy = 0, fifo_count = 0.
- Reset asserted mid-operation discards queued and in-flight work. No result is emitted for it.
- Push: occurs when instr_valid && instr_ready. instr_ready = (count < DEPTH) and depends only on registered count. There is no full-bypass: a push while full is refused even if a pop happens the same cycle.
- Simultaneous push and pop with 0 < count < DEPTH leaves count unchanged.
- A push into an empty FIFO cannot pop in the same cycle (no fall-through).
- Pointers wrap modulo DEPTH.
- FSM states:
  - IDLE: if count > 0, pop the head into alu_in and go to EXEC. Otherwise stay; alu_in holds its last value.
  - EXEC: one settle cycle for the ALU. At the edge, res_out <= alu_sum, res_valid <= 1, go to WAIT.
  - WAIT: res_valid = 1, and res_out and alu_in stay stable.
    - On res_ready && count > 0: pop the next word into alu_in, res_valid <= 0, go to EXEC.
    - On res_ready && count == 0: res_valid <= 0, go to IDLE.
    - Otherwise stay.
- Latency: a word pushed into an empty idle block at edge 0 gives alu_in at edge 1 and res_valid at edge 2.
- Throughput: at most one result every 2 cycles.
- Results leave in push order. Widths are fixed; no arithmetic is performed on alu_sum.

Optional Feature:
- Macro ALU_ISSUE_STATS_EN.
- Defined:
  - Adds output done_cnt [15:0], reset 0.
  - Increments on each res_valid && res_ready handshake; wraps from 16'hFFFF to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package alu_pkg holds:
  - INSTR_W = 12 and RES_W = 4 constants.
  - Enum typedef issue_state_t {IDLE, EXEC, WAIT}.
  - Typedef instr_t as logic [INSTR_W-1:0].
- One natural sub-module, alu_instr_fifo, holds the storage, pointers, count and ready logic. The FSM and result register live in the top.

Test Plan:
- All scenarios use a bench stub for the ALU: alu_sum = alu_in[7:4] + alu_in[3:0] mod 16.
- Reset and single instruction: after reset, outputs are 0 and instr_ready = 1. Push 12'h33A with res_ready = 1 -> alu_in = 12'h33A at edge 1; res_out = 4'hD and res_valid = 1 at edge 2.
- Stream in order: push 12'h33A, 12'h32A, 12'h323, 12'h324 back-to-back with res_ready = 1 -> results D, C, 5, 6 in order, one every 2 cycles. busy falls after the last handshake.
- Full and back-pressure: hold res_ready = 0 and push 6 words -> 1 issued and DEPTH = 4 buffered. instr_ready = 0 with fifo_count = 4. alu_in and res_out stay stable in WAIT.
- Release back-pressure: after the full case, set res_ready = 1 -> the remaining results drain in push order.
- Reset mid-operation: assert rst_n = 0 while in WAIT with 3 words queued -> immediately res_valid = 0 and fifo_count = 0. After release, no stale result appears.
- Stats (ALU_ISSUE_STATS_EN defined): 4 completed handshakes -> done_cnt = 4. Stalled cycles do not increment it.
